// File: rtl/response_signature.sv
// Response compactor: folds a 1-bit response stream into a 16-bit CRC signature
// over 2^CNT_W accepted samples. Optional ones counter is enabled by defining ONES_COUNT_EN.
//
// state  | meaning
// IDLE   | waiting for start after reset
// RUN    | sweep in progress, accepting samples
// DONE   | sweep finished, verdict held until next start
module response_signature #(
  parameter int          CNT_W    = 16,
  parameter logic [15:0] POLY     = 16'h1021,
  parameter logic [15:0] SEED     = 16'hFFFF,
  parameter logic [15:0] EXPECTED = 16'h0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sample_valid,
  input  logic             z_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      signature,
  output logic [CNT_W-1:0] sample_index,
  output logic [CNT_W:0]   ones_count
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [CNT_W-1:0] IDX_ONE  = 1;
  localparam logic [CNT_W-1:0] IDX_LAST = '1;

  state_t             state_q, state_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic [15:0]        sig_q, sig_d;
  logic [15:0]        lfsr_q, lfsr_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic               fb;
  logic [15:0]        lfsr_upd;

`ifdef ONES_COUNT_EN
  localparam logic [CNT_W:0] ONES_ONE = 1;
  logic [CNT_W:0] ones_q, ones_d;
`endif

  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    done_d   = done_q;
    pass_d   = pass_q;
    sig_d    = sig_q;
    lfsr_d   = lfsr_q;
    idx_d    = idx_q;
`ifdef ONES_COUNT_EN
    ones_d   = ones_q;
`endif
    fb       = lfsr_q[15] ^ z_in;
    lfsr_upd = {lfsr_q[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);

    case (state_q)
      S_IDLE, S_DONE: begin
        // sample_valid is ignored here, including on the start cycle itself
        if (start) begin
          state_d = S_RUN;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          lfsr_d  = SEED;
          idx_d   = '0;
`ifdef ONES_COUNT_EN
          ones_d  = '0;
`endif
        end
      end
      S_RUN: begin
        if (sample_valid) begin
          lfsr_d = lfsr_upd;
          idx_d  = idx_q + IDX_ONE;
`ifdef ONES_COUNT_EN
          if (z_in) ones_d = ones_q + ONES_ONE;
`endif
          if (idx_q == IDX_LAST) begin
            sig_d   = lfsr_upd;
            pass_d  = (lfsr_upd == EXPECTED);
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_DONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      sig_q   <= '0;
      lfsr_q  <= '0;
      idx_q   <= '0;
`ifdef ONES_COUNT_EN
      ones_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      sig_q   <= sig_d;
      lfsr_q  <= lfsr_d;
      idx_q   <= idx_d;
`ifdef ONES_COUNT_EN
      ones_q  <= ones_d;
`endif
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign signature    = sig_q;
  assign sample_index = idx_q;
`ifdef ONES_COUNT_EN
  assign ones_count   = ones_q;
`else
  assign ones_count   = '0;
`endif

endmodule
